// File: rtl/lv_owt_tx_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// lv_owt_tx_ctrl_pkg
// Shared OWT definitions: FSM state encodings, default field widths, CRC8
// polynomial and the tail level pattern used by the LV OWT transmitter.
// -----------------------------------------------------------------------------
package lv_owt_tx_ctrl_pkg;

   // OWT FSM state encodings (common to the TX and RX paths)
   localparam int                      OWT_FSM_ST_W      = 3;
   localparam logic [OWT_FSM_ST_W-1:0] OWT_FSM_IDLE      = 3'd0;
   localparam logic [OWT_FSM_ST_W-1:0] OWT_FSM_SYNC_HEAD = 3'd1;
   localparam logic [OWT_FSM_ST_W-1:0] OWT_FSM_SYNC_TAIL = 3'd2;
   localparam logic [OWT_FSM_ST_W-1:0] OWT_FSM_CMD       = 3'd3;
   localparam logic [OWT_FSM_ST_W-1:0] OWT_FSM_NML_DATA  = 3'd4;
   localparam logic [OWT_FSM_ST_W-1:0] OWT_FSM_ADC_DATA  = 3'd5;
   localparam logic [OWT_FSM_ST_W-1:0] OWT_FSM_CRC       = 3'd6;
   localparam logic [OWT_FSM_ST_W-1:0] OWT_FSM_END_TAIL  = 3'd7;

   typedef enum logic [OWT_FSM_ST_W-1:0] {
      ST_IDLE      = OWT_FSM_IDLE,
      ST_SYNC_HEAD = OWT_FSM_SYNC_HEAD,
      ST_SYNC_TAIL = OWT_FSM_SYNC_TAIL,
      ST_CMD       = OWT_FSM_CMD,
      ST_NML_DATA  = OWT_FSM_NML_DATA,
      ST_ADC_DATA  = OWT_FSM_ADC_DATA,
      ST_CRC       = OWT_FSM_CRC,
      ST_END_TAIL  = OWT_FSM_END_TAIL
   } owt_fsm_st_e;

   // Default frame field widths
   localparam int OWT_EXT_CYC_NUM_DEF  = 4;
   localparam int OWT_SYNC_BIT_NUM_DEF = 12;
   localparam int OWT_TAIL_BIT_NUM_DEF = 4;
   localparam int OWT_CMD_BIT_NUM_DEF  = 8;
   localparam int OWT_DATA_BIT_NUM_DEF = 8;
   localparam int OWT_CRC_BIT_NUM_DEF  = 8;

   // CRC8: x^8 + x^2 + x + 1
   localparam logic [7:0] OWT_CRC8_POLY = 8'h07;

   // Raw half-bit levels of each tail, sent MSB first
   localparam logic [3:0] OWT_TAIL_PAT = 4'b1100;

endpackage

// File: rtl/lv_owt_tx_ctrl_crc8_serial_sr.sv
// -----------------------------------------------------------------------------
// crc8_serial_sr
// Bit-serial CRC (MSB first, init 0, no reflection, no xorout).
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_vld          shift i_data into the CRC this cycle
//   i_data         serial data bit
//   i_new_calc     clear the CRC to start a new message (wins over i_vld)
//   o_vld_crc      current CRC value, registered
// -----------------------------------------------------------------------------
module crc8_serial_sr
   import lv_owt_tx_ctrl_pkg::*;
#(
   parameter int               CRC_W = OWT_CRC_BIT_NUM_DEF,
   parameter logic [CRC_W-1:0] POLY  = CRC_W'(OWT_CRC8_POLY)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_vld,
   input  logic             i_data,
   input  logic             i_new_calc,
   output logic [CRC_W-1:0] o_vld_crc
);

   logic [CRC_W-1:0] r_crc;
   logic             w_fb;

   assign w_fb      = r_crc[CRC_W-1] ^ i_data;
   assign o_vld_crc = r_crc;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_new_calc) begin
         r_crc <= '0;
      end else if (i_vld) begin
         r_crc <= {r_crc[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
      end
   end

endmodule

// File: rtl/lv_owt_tx_ctrl.sv
// -----------------------------------------------------------------------------
// lv_owt_tx_ctrl
// LV-side one-wire transmitter. Serialises one Manchester frame per request:
// sync head ('0' bits), sync tail (1100), cmd, data, CRC8, end tail (1100).
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_owt_tx_req        single-cycle request, honoured only in IDLE
//   i_owt_tx_cmd/data   frame payload, sampled with the request
//   o_owt_tx_busy       high while the frame is on the wire
//   o_owt_tx_done       one-cycle pulse after the last half-bit
//   o_owt_tx_cmd_lock   command of the last accepted frame
//   o_lv_hv_owt_tx      registered line output, idles low
// -----------------------------------------------------------------------------
module lv_owt_tx_ctrl
   import lv_owt_tx_ctrl_pkg::*;
#(
   parameter int OWT_EXT_CYC_NUM  = OWT_EXT_CYC_NUM_DEF,
   parameter int OWT_SYNC_BIT_NUM = OWT_SYNC_BIT_NUM_DEF,
   parameter int OWT_TAIL_BIT_NUM = OWT_TAIL_BIT_NUM_DEF,
   parameter int OWT_CMD_BIT_NUM  = OWT_CMD_BIT_NUM_DEF,
   parameter int OWT_DATA_BIT_NUM = OWT_DATA_BIT_NUM_DEF,
   parameter int OWT_CRC_BIT_NUM  = OWT_CRC_BIT_NUM_DEF
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_owt_tx_req,
   input  logic [OWT_CMD_BIT_NUM-1:0]  i_owt_tx_cmd,
   input  logic [OWT_DATA_BIT_NUM-1:0] i_owt_tx_data,
   output logic                       o_owt_tx_busy,
   output logic                       o_owt_tx_done,
   output logic [OWT_CMD_BIT_NUM-1:0]  o_owt_tx_cmd_lock,
   output logic                       o_lv_hv_owt_tx
);

   localparam int HB_W  = (OWT_EXT_CYC_NUM > 1) ? $clog2(OWT_EXT_CYC_NUM) : 1;
   localparam int CNT_W = 8;   // bit/slot counter, covers fields up to 256
   localparam logic [OWT_TAIL_BIT_NUM-1:0] W_TAIL_PAT = OWT_TAIL_BIT_NUM'(OWT_TAIL_PAT);

   owt_fsm_st_e                 r_state;
   logic [HB_W-1:0]             r_hb_cnt;
   logic                        r_half;      // 0: first half-bit, 1: second
   logic [CNT_W-1:0]            r_bit_cnt;
   logic [OWT_CMD_BIT_NUM-1:0]  r_cmd_sr;
   logic [OWT_DATA_BIT_NUM-1:0] r_data_sr;
   logic [OWT_CRC_BIT_NUM-1:0]  r_crc_sr;
   logic [OWT_TAIL_BIT_NUM-1:0] r_tail_sr;
   logic [OWT_CMD_BIT_NUM-1:0]  r_cmd_lock;
   logic                        r_busy;
   logic                        r_done;
   logic                        r_line;

   logic                        w_slot_end;
   logic [CNT_W-1:0]            w_bit_lim;
   logic                        w_last_bit;
   logic                        w_crc_vld;
   logic                        w_crc_bit;
   logic                        w_crc_new;
   logic [OWT_CRC_BIT_NUM-1:0]  w_crc;

   assign w_slot_end = (r_hb_cnt == HB_W'(OWT_EXT_CYC_NUM - 1));

   always_comb begin
      w_bit_lim = '0;
      case (r_state)
         ST_SYNC_HEAD: w_bit_lim = CNT_W'(OWT_SYNC_BIT_NUM - 1);
         ST_SYNC_TAIL: w_bit_lim = CNT_W'(OWT_TAIL_BIT_NUM - 1);
         ST_CMD:       w_bit_lim = CNT_W'(OWT_CMD_BIT_NUM - 1);
         ST_NML_DATA:  w_bit_lim = CNT_W'(OWT_DATA_BIT_NUM - 1);
         ST_CRC:       w_bit_lim = CNT_W'(OWT_CRC_BIT_NUM - 1);
         ST_END_TAIL:  w_bit_lim = CNT_W'(OWT_TAIL_BIT_NUM - 1);
         default:      w_bit_lim = '0;
      endcase
   end
   assign w_last_bit = (r_bit_cnt == w_bit_lim);

   // CRC takes each cmd/data bit once, in the first cycle of its first half
   assign w_crc_vld = ((r_state == ST_CMD) || (r_state == ST_NML_DATA)) &&
                      !r_half && (r_hb_cnt == '0);
   assign w_crc_bit = (r_state == ST_CMD) ? r_cmd_sr[OWT_CMD_BIT_NUM-1]
                                          : r_data_sr[OWT_DATA_BIT_NUM-1];
   assign w_crc_new = (r_state == ST_IDLE) && i_owt_tx_req;

   crc8_serial_sr #(
      .CRC_W (OWT_CRC_BIT_NUM),
      .POLY  (OWT_CRC_BIT_NUM'(OWT_CRC8_POLY))
   ) u_crc (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_vld      (w_crc_vld),
      .i_data     (w_crc_bit),
      .i_new_calc (w_crc_new),
      .o_vld_crc  (w_crc)
   );

   // The line register always loads the level of the slot that starts next,
   // so every transition lands exactly on a half-bit boundary. The second
   // half of any Manchester bit is simply the inverse of the first.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_hb_cnt   <= '0;
         r_half     <= 1'b0;
         r_bit_cnt  <= '0;
         r_cmd_sr   <= '0;
         r_data_sr  <= '0;
         r_crc_sr   <= '0;
         r_tail_sr  <= '0;
         r_cmd_lock <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_line     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if ((r_state == ST_IDLE) || w_slot_end) r_hb_cnt <= '0;
         else                                    r_hb_cnt <= r_hb_cnt + 1'b1;

         case (r_state)
            ST_IDLE: begin
               if (i_owt_tx_req) begin
                  r_state    <= ST_SYNC_HEAD;
                  r_cmd_sr   <= i_owt_tx_cmd;
                  r_data_sr  <= i_owt_tx_data;
                  r_cmd_lock <= i_owt_tx_cmd;
                  r_half     <= 1'b0;
                  r_bit_cnt  <= '0;
                  r_busy     <= 1'b1;
                  r_line     <= 1'b0;   // first half of a sync '0'
               end
            end

            ST_SYNC_HEAD: if (w_slot_end) begin
               if (!r_half) begin
                  r_half <= 1'b1;
                  r_line <= ~r_line;
               end else begin
                  r_half <= 1'b0;
                  if (w_last_bit) begin
                     r_state   <= ST_SYNC_TAIL;
                     r_bit_cnt <= '0;
                     r_line    <= W_TAIL_PAT[OWT_TAIL_BIT_NUM-1];
                     r_tail_sr <= W_TAIL_PAT << 1;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                     r_line    <= 1'b0;
                  end
               end
            end

            ST_SYNC_TAIL: if (w_slot_end) begin
               if (w_last_bit) begin
                  r_state   <= ST_CMD;
                  r_bit_cnt <= '0;
                  r_half    <= 1'b0;
                  r_line    <= r_cmd_sr[OWT_CMD_BIT_NUM-1];
               end else begin
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  r_line    <= r_tail_sr[OWT_TAIL_BIT_NUM-1];
                  r_tail_sr <= r_tail_sr << 1;
               end
            end

            ST_CMD: if (w_slot_end) begin
               if (!r_half) begin
                  r_half <= 1'b1;
                  r_line <= ~r_line;
               end else begin
                  r_half <= 1'b0;
                  if (w_last_bit) begin
                     r_state   <= ST_NML_DATA;
                     r_bit_cnt <= '0;
                     r_line    <= r_data_sr[OWT_DATA_BIT_NUM-1];
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                     r_cmd_sr  <= {r_cmd_sr[OWT_CMD_BIT_NUM-2:0], 1'b0};
                     r_line    <= r_cmd_sr[OWT_CMD_BIT_NUM-2];
                  end
               end
            end

            ST_NML_DATA: if (w_slot_end) begin
               if (!r_half) begin
                  r_half <= 1'b1;
                  r_line <= ~r_line;
               end else begin
                  r_half <= 1'b0;
                  if (w_last_bit) begin
                     // Last data bit was fed on its first half, so the CRC
                     // is final here; freeze it into the output shifter.
                     r_state   <= ST_CRC;
                     r_bit_cnt <= '0;
                     r_crc_sr  <= w_crc;
                     r_line    <= w_crc[OWT_CRC_BIT_NUM-1];
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                     r_data_sr <= {r_data_sr[OWT_DATA_BIT_NUM-2:0], 1'b0};
                     r_line    <= r_data_sr[OWT_DATA_BIT_NUM-2];
                  end
               end
            end

            ST_CRC: if (w_slot_end) begin
               if (!r_half) begin
                  r_half <= 1'b1;
                  r_line <= ~r_line;
               end else begin
                  r_half <= 1'b0;
                  if (w_last_bit) begin
                     r_state   <= ST_END_TAIL;
                     r_bit_cnt <= '0;
                     r_line    <= W_TAIL_PAT[OWT_TAIL_BIT_NUM-1];
                     r_tail_sr <= W_TAIL_PAT << 1;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                     r_crc_sr  <= {r_crc_sr[OWT_CRC_BIT_NUM-2:0], 1'b0};
                     r_line    <= r_crc_sr[OWT_CRC_BIT_NUM-2];
                  end
               end
            end

            // After the last slot the FSM lingers here for the done cycle,
            // so a request coinciding with done is not accepted.
            ST_END_TAIL: begin
               if (r_done) begin
                  r_state <= ST_IDLE;
               end else if (w_slot_end) begin
                  if (w_last_bit) begin
                     r_done <= 1'b1;
                     r_busy <= 1'b0;
                     r_line <= 1'b0;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                     r_line    <= r_tail_sr[OWT_TAIL_BIT_NUM-1];
                     r_tail_sr <= r_tail_sr << 1;
                  end
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_owt_tx_busy     = r_busy;
   assign o_owt_tx_done     = r_done;
   assign o_owt_tx_cmd_lock = r_cmd_lock;
   assign o_lv_hv_owt_tx    = r_line;

endmodule

// File: tb/tb_lv_owt_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lv_owt_tx_ctrl
// Two instances: u_dut_d at the default 4 clocks per half-bit and u_dut_f at
// 1 clock per half-bit. Expected frames are built from the frame rules
// (field order, Manchester mapping, bytewise CRC8) and compared per cycle.
// -----------------------------------------------------------------------------
module tb_lv_owt_tx_ctrl;

   localparam int SYNC = 12;
   localparam int TAIL = 4;
   localparam int H    = 2*SYNC + TAIL + 2*(8+8+8) + TAIL;   // 80 half-bits
   localparam int CMD_S  = 2*SYNC + TAIL;                    // first cmd slot
   localparam int DATA_S = CMD_S + 16;
   localparam int CRC_S  = DATA_S + 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_d, req_f;
   logic [7:0] cmd_d, data_d, cmd_f, data_f;
   logic       busy_d, done_d, line_d, busy_f, done_f, line_f;
   logic [7:0] lock_d, lock_f;

   always #5 clk = ~clk;

   lv_owt_tx_ctrl #(.OWT_EXT_CYC_NUM(4)) u_dut_d (
      .i_clk(clk), .i_rst(rst), .i_owt_tx_req(req_d), .i_owt_tx_cmd(cmd_d),
      .i_owt_tx_data(data_d), .o_owt_tx_busy(busy_d), .o_owt_tx_done(done_d),
      .o_owt_tx_cmd_lock(lock_d), .o_lv_hv_owt_tx(line_d));

   lv_owt_tx_ctrl #(.OWT_EXT_CYC_NUM(1)) u_dut_f (
      .i_clk(clk), .i_rst(rst), .i_owt_tx_req(req_f), .i_owt_tx_cmd(cmd_f),
      .i_owt_tx_data(data_f), .o_owt_tx_busy(busy_f), .o_owt_tx_done(done_f),
      .o_owt_tx_cmd_lock(lock_f), .o_lv_hv_owt_tx(line_f));

   int   n_cmp = 0;
   int   n_bad = 0;
   logic exp_seq [H];
   logic cap     [H];

   typedef struct {
      bit         fast;
      logic [7:0] cmd;
      logic [7:0] data;
      logic [7:0] crc;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Bytewise CRC8 poly 0x07 over {a, b}
   function automatic logic [7:0] crc8_model(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] c;
      logic [7:0] msg [2];
      msg[0] = a; msg[1] = b;
      c = 8'h00;
      for (int m = 0; m < 2; m++) begin
         c = c ^ msg[m];
         for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      end
      return c;
   endfunction

   // Expected half-bit levels of a whole frame
   task automatic build_exp(input logic [7:0] c, input logic [7:0] d, input logic [7:0] r);
      logic [23:0] pl;
      logic [3:0]  tp;
      int          p;
      pl = {c, d, r};
      tp = 4'b1100;
      p  = 0;
      for (int i = 0; i < SYNC; i++) begin exp_seq[p] = 1'b0; exp_seq[p+1] = 1'b1; p += 2; end
      for (int i = 0; i < TAIL; i++) begin exp_seq[p] = tp[3-i]; p++; end
      for (int i = 23; i >= 0; i--) begin exp_seq[p] = pl[i]; exp_seq[p+1] = ~pl[i]; p += 2; end
      for (int i = 0; i < TAIL; i++) begin exp_seq[p] = tp[3-i]; p++; end
   endtask

   task automatic drive(input bit fast, input logic rq, input logic [7:0] c, input logic [7:0] d);
      if (fast) begin req_f = rq; cmd_f = c; data_f = d; end
      else      begin req_d = rq; cmd_d = c; data_d = d; end
   endtask

   function automatic logic line_of(input bit fast); return fast ? line_f : line_d; endfunction
   function automatic logic busy_of(input bit fast); return fast ? busy_f : busy_d; endfunction
   function automatic logic done_of(input bit fast); return fast ? done_f : done_d; endfunction
   function automatic logic [7:0] lock_of(input bit fast); return fast ? lock_f : lock_d; endfunction

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Issues a request in the current cycle, follows the frame cycle by cycle
   // and returns positioned in the done cycle. Optionally injects a second
   // request inj_k cycles after the first line cycle.
   task automatic run_frame(input string tag, input bit fast, input logic [7:0] c,
                            input logic [7:0] d, input logic [7:0] r,
                            input int inj_k, input logic [7:0] inj_c);
      int ext, n, bad_line, bad_busy, bad_lock;
      logic [7:0] dc, dd, dr;
      ext = fast ? 1 : 4;
      n   = H * ext;
      bad_line = 0; bad_busy = 0; bad_lock = 0;
      build_exp(c, d, r);
      drive(fast, 1'b1, c, d);
      @(posedge clk); #1;
      for (int k = 0; k < n; k++) begin
         if (k == inj_k) drive(fast, 1'b1, inj_c, 8'h55);
         else            drive(fast, 1'b0, 8'h00, 8'h00);
         if (k % ext == 0) cap[k/ext] = line_of(fast);
         if (line_of(fast) !== exp_seq[k/ext]) bad_line++;
         if (busy_of(fast) !== 1'b1 || done_of(fast) !== 1'b0) bad_busy++;
         if (lock_of(fast) !== c) bad_lock++;
         @(posedge clk); #1;
      end
      drive(fast, 1'b0, 8'h00, 8'h00);
      chk({tag, "_line_bad_cycles"}, bad_line, 0);
      chk({tag, "_busy_bad_cycles"}, bad_busy, 0);
      chk({tag, "_lock_bad_cycles"}, bad_lock, 0);
      chk({tag, "_done_busy_line"}, {done_of(fast), busy_of(fast), line_of(fast)}, 3'b100);
      for (int i = 0; i < 8; i++) begin
         dc[7-i] = cap[CMD_S  + 2*i];
         dd[7-i] = cap[DATA_S + 2*i];
         dr[7-i] = cap[CRC_S  + 2*i];
      end
      chk({tag, "_cmd_field"}, dc, c);
      chk({tag, "_data_field"}, dd, d);
      chk({tag, "_crc_field"}, dr, r);
   endtask

   initial begin
      vec_t tbl [4];
      int   bad;
      logic [7:0] rc, rd;

      tbl[0] = '{fast: 1'b0, cmd: 8'h85, data: 8'h3C, crc: 8'h43};
      tbl[1] = '{fast: 1'b0, cmd: 8'h1F, data: 8'h00, crc: 8'h94};
      tbl[2] = '{fast: 1'b0, cmd: 8'h00, data: 8'h00, crc: 8'h00};
      tbl[3] = '{fast: 1'b1, cmd: 8'hFF, data: 8'hFF, crc: 8'h24};

      rst = 1'b1;
      drive(1'b0, 1'b0, 8'h00, 8'h00);
      drive(1'b1, 1'b0, 8'h00, 8'h00);
      idle(3);
      chk("reset_d", {line_d, busy_d, done_d, lock_d}, 0);
      chk("reset_f", {line_f, busy_f, done_f, lock_f}, 0);
      rst = 1'b0;
      idle(2);

      // Table-driven frames
      for (int v = 0; v < 4; v++) begin
         run_frame($sformatf("vec%0d", v), tbl[v].fast, tbl[v].cmd, tbl[v].data,
                   tbl[v].crc, -1, 8'h00);
         if (tbl[v].cmd == 8'h00 && tbl[v].data == 8'h00) begin
            bad = 0;
            for (int s = CMD_S; s < CRC_S + 16; s += 2)
               if (cap[s] !== 1'b0 || cap[s+1] !== 1'b1) bad++;
            chk("zero_frame_low_high_bits", bad, 0);
         end
         if (tbl[v].fast) begin
            bad = 0;
            for (int s = CMD_S; s < CRC_S; s++) if (cap[s] === cap[s-1]) bad++;
            chk("fast_ff_toggle_every_cycle", bad, 0);
         end
         idle(2);
      end

      // Request while busy and at the done cycle are ignored; one later accepted
      run_frame("busy_req", 1'b0, 8'h85, 8'h3C, 8'h43, 49, 8'hAA);
      drive(1'b0, 1'b1, 8'hAA, 8'h55);          // done cycle
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 8'h00, 8'h00);
      chk("req_at_done_ignored", {busy_d, lock_d}, {1'b0, 8'h85});
      run_frame("after_done", 1'b0, 8'h1F, 8'h00, 8'h94, -1, 8'h00);
      idle(5);
      chk("lock_holds_after_frame", lock_d, 8'h1F);

      // Reset in the middle of a frame
      drive(1'b0, 1'b1, 8'h85, 8'h3C);
      @(posedge clk); #1;                       // T+1
      drive(1'b0, 1'b0, 8'h00, 8'h00);
      idle(149);                                // T+150
      rst = 1'b1;
      @(posedge clk); #1;                       // T+151
      rst = 1'b0;
      chk("mid_reset_outputs", {line_d, busy_d, done_d, lock_d}, 0);
      bad = 0;
      for (int k = 0; k < 400; k++) begin
         if (done_d !== 1'b0 || busy_d !== 1'b0 || line_d !== 1'b0) bad++;
         @(posedge clk); #1;
      end
      chk("mid_reset_no_done", bad, 0);
      run_frame("post_reset", 1'b0, 8'h85, 8'h3C, 8'h43, -1, 8'h00);
      idle(2);

      // Randomized frames against the CRC model
      for (int t = 0; t < 10; t++) begin
         rc = 8'($urandom);
         rd = rc[7] ? 8'($urandom) : 8'h00;
         run_frame($sformatf("rand%0d", t), (t % 4) != 0, rc, rd, crc8_model(rc, rd), -1, 8'h00);
         idle(1 + (t % 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lv_owt_tx_ctrl.md
# lv_owt_tx_ctrl

LV-side one-wire (OWT) transmitter that sits directly upstream of the LV OWT receive path. It takes a command/data request from the LV control unit and serialises one Manchester-coded frame onto the LV→HV wire: sync head, sync tail, cmd, data, CRC8, end tail. It also latches the issued command as `o_owt_tx_cmd_lock`, which the receive path compares against the echoed command.

## Interface
Parameters:
- `OWT_EXT_CYC_NUM`, 4: clocks per half-bit.
- `OWT_SYNC_BIT_NUM`, 12: Manchester '0' bits in the sync head.
- `OWT_TAIL_BIT_NUM`, 4: raw half-bit slots in each tail.
- `OWT_CMD_BIT_NUM`, 8: command width; MSB=1 means write, MSB=0 means read.
- `OWT_DATA_BIT_NUM`, 8: data field width.
- `OWT_CRC_BIT_NUM`, 8: CRC width.

Ports:
- `i_clk`  in  1  sole clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_owt_tx_req`  in  1  single-cycle request; sampled only in IDLE.
- `i_owt_tx_cmd`  in  OWT_CMD_BIT_NUM  command, sampled with req.
- `i_owt_tx_data`  in  OWT_DATA_BIT_NUM  data, sampled with req. For reads the LV control unit drives 0.
- `o_owt_tx_busy`  out  1  frame in progress.
- `o_owt_tx_done`  out  1  one-cycle pulse at frame end.
- `o_owt_tx_cmd_lock`  out  OWT_CMD_BIT_NUM  command of the last accepted frame.
- `o_lv_hv_owt_tx`  out  1  registered line output; idle level is low.

## Operation
- **Half-bit timer.** `hb_cnt` counts 0..OWT_EXT_CYC_NUM-1 while not in IDLE. A half-bit slot ends when `hb_cnt` reaches OWT_EXT_CYC_NUM-1.
- **Manchester coding.**
  - Bit '0' is low then high.
  - Bit '1' is high then low.
  - Bits are sent MSB first.
- **FSM states:** IDLE, SYNC_HEAD, SYNC_TAIL, CMD, NML_DATA, CRC, END_TAIL. Encodings come from the shared OWT FSM constants; ADC_DATA is unused by TX.
- **IDLE → SYNC_HEAD** on `i_owt_tx_req`.
  - Load the cmd/data shift registers.
  - Update `o_owt_tx_cmd_lock`.
  - Clear the CRC.
- **SYNC_HEAD:** OWT_SYNC_BIT_NUM Manchester '0' bits, then → SYNC_TAIL.
- **SYNC_TAIL:** OWT_TAIL_BIT_NUM raw half-bit slots with levels 1,1,0,0, then → CMD.
- **CMD:** OWT_CMD_BIT_NUM bits, then → NML_DATA.
- **NML_DATA:** OWT_DATA_BIT_NUM bits, then → CRC.
- **CRC:** OWT_CRC_BIT_NUM bits, then → END_TAIL.
- **END_TAIL:** levels 1,1,0,0, then → IDLE with `o_owt_tx_done` pulsed.
- **CRC8 definition:**
  - Polynomial x^8+x^2+x+1 (0x07), init 0x00, no reflection, no xorout.
  - Fed serially with each cmd and data bit at the first half-bit of that bit.
  - Frozen before the CRC state and shifted out MSB first.
- `i_owt_tx_req` while busy is ignored; it is not queued.
- A request in the same cycle as the `done` pulse is ignored, because the FSM is still in END_TAIL. The earliest acceptance is the cycle after `done`.
- `o_owt_tx_cmd_lock` holds until the next accepted request.

## Timing
- **Reset values:**
  - `o_lv_hv_owt_tx`=0, `o_owt_tx_busy`=0, `o_owt_tx_done`=0, `o_owt_tx_cmd_lock`=0.
  - FSM=IDLE; `hb_cnt`, shift registers and CRC are all 0.
- **Reset mid-frame:** the line drops low on the next edge, the frame is abandoned and no `done` is issued.
- **Frame length** H = 2·SYNC + TAIL + 2·(CMD+DATA+CRC) + TAIL half-bits; H = 80 at defaults.
- **Cycle timeline** for a request accepted at cycle T:
  - T+1: first half-bit appears on `o_lv_hv_owt_tx`.
  - T+1 … T+H·EXT: `o_owt_tx_busy`=1; H·EXT = 320 cycles at defaults.
  - T+H·EXT+1: `o_owt_tx_done`=1, `busy`=0, line low.
- Every line transition is aligned to a half-bit boundary, so no glitches occur. Output comes straight from a flop.

## Structure
- **Shared package:**
  - OWT FSM state constants and OWT_FSM_ST_W.
  - The OWT_* field widths.
  - CRC8 polynomial constant.
  - Tail pattern constant 4'b1100.
- **Sub-module `crc8_serial_sr`:** serial CRC8 with synchronous active-high reset. Ports: `i_vld`, `i_data`, `i_new_calc`, `o_vld_crc`.
- Everything else is inline: FSM, half-bit timer, bit counter, shift registers.

## Test plan
- **Defaults, write cmd 0x85, data 0x3C:**
  - Decoded line gives 12×'0', then 1100, then 0x85, 0x3C, then CRC equal to the 0x07 model of {0x85,0x3C}, then 1100.
  - `busy` lasts 320 cycles; `done` arrives at T+321.
- **Read cmd 0x1F, data 0x00:** NML_DATA still 8 bits; `o_owt_tx_cmd_lock`=0x1F from T+1 until the next accept.
- **cmd 0x00, data 0x00:** CRC field is 0x00; every bit is Manchester low→high.
- **Second `req` at T+50 with cmd 0xAA:**
  - Ignored; the frame is unchanged and the lock stays 0x85.
  - `req` at the `done` cycle is also ignored; `req` one cycle later is accepted.
- **Assert `i_rst` for one cycle at T+150:**
  - Next cycle: line=0, busy=0, lock=0, no `done`.
  - A fresh request afterwards produces a complete, correct frame.
- **`OWT_EXT_CYC_NUM`=1, cmd 0xFF, data 0xFF:** the line toggles every cycle during cmd/data, and the frame length is 80 cycles.
